i_memory_stage: RTL

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage and its EX/MEM latch.
- Consumes the EX/MEM outputs: control bits, ALU result, store data and destination register.
- Owns the word-addressed data memory and produces PCSrc for IF.
- Contains the MEM/WB pipeline register that feeds writeback.

---
 rtl/i_memory_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/i_memory_stage.sv
// i_memory_stage: MEM stage of the 5-stage MIPS pipeline.
// Holds the word-addressed data memory, derives PCSrc for IF and owns the
// MEM/WB pipeline register that feeds writeback.
// Optional build macro: DMEM_MISALIGN_CHK_EN adds the mem_misaligned output,
// suppresses misaligned stores and squashes misaligned loads.
module i_memory_stage #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_ctl,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2out,
  input  logic [4:0]        five_bit_muxout,
  input  logic              hold,
  input  logic              flush,
  output logic              PCSrc,
  output logic              MEM_WB_regwrite,
  output logic              MEM_WB_memtoreg,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_alu_result,
`ifdef DMEM_MISALIGN_CHK_EN
  output logic              mem_misaligned,
`endif
  output logic [4:0]        mem_write_reg
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 r_regwrite;
  logic                 r_memtoreg;
  logic [DATA_W-1:0]    r_read_data;
  logic [DATA_W-1:0]    r_alu_result;
  logic [4:0]           r_write_reg;

  logic [ADDR_BITS-1:0] w_index;
  logic                 w_misaligned;
  logic                 w_store_en;
  logic [DATA_W-1:0]    w_load_data;
  logic                 w_unused;

  // Byte address to word index; upper bits drop out so accesses wrap.
  assign w_index = alu_result[ADDR_BITS+1:2];

  // Bits outside the word index are intentionally ignored.
  assign w_unused = ^{alu_result[DATA_W-1:ADDR_BITS+2], alu_result[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_misaligned = (memread | memwrite) & (alu_result[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Branch decision goes straight to the IF PC mux with no register.
  assign PCSrc = branch & zero;

  // Rst is sampled here so a store coinciding with reset is dropped.
  assign w_store_en = memwrite & ~hold & ~rst & ~w_misaligned;

  // Read happens before this edge's write, giving read-before-write.
  always_comb begin
    w_load_data = '0;
    if (memread && !w_misaligned) begin
      w_load_data = r_mem[w_index];
    end
  end

  // Data memory write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      r_mem[w_index] <= rdata2out;
    end
  end

  // MEM/WB register: reset, then hold, then flush (bubble), then capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
    end else if (!hold) begin
      r_regwrite   <= ~flush & wb_ctl[1] & ~(memread & w_misaligned);
      r_memtoreg   <= ~flush & wb_ctl[0];
      r_read_data  <= w_load_data;
      r_alu_result <= alu_result;
      r_write_reg  <= five_bit_muxout;
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic r_misaligned;

  // Misalignment flag travels with the MEM/WB contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (!hold) begin
      r_misaligned <= w_misaligned;
    end
  end

  assign mem_misaligned = r_misaligned;
`endif

  assign MEM_WB_regwrite = r_regwrite;
  assign MEM_WB_memtoreg = r_memtoreg;
  assign read_data       = r_read_data;
  assign mem_alu_result  = r_alu_result;
  assign mem_write_reg   = r_write_reg;

endmodule
